// File: rtl/pipe_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard: write kinds,
// special register numbers, the scoreboard entry type and a helper.
package pipe_pkg;

    // Destination write kinds as presented on id_wr_kind
    localparam logic [1:0] WR_ALU  = 2'd0;
    localparam logic [1:0] WR_LOAD = 2'd1;
    localparam logic [1:0] WR_LINK = 2'd2;
    localparam logic [1:0] WR_RSVD = 2'd3;

    // Architectural register numbers with special meaning
    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 31;

    // Entry field widths; the address field is wide enough for any ADDR_W <= 8
    localparam int SB_ADDR_W = 8;
    localparam int SB_CNT_W  = 4;

    // One in-flight register write
    typedef struct packed {
        logic                 v;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_CNT_W-1:0]  cnt;
    } sb_entry_t;

    localparam sb_entry_t SB_EMPTY = sb_entry_t'(13'd0);

    // Forwarding countdown step, saturating at zero
    function automatic logic [SB_CNT_W-1:0] cnt_dec(input logic [SB_CNT_W-1:0] c);
        logic [SB_CNT_W-1:0] r;
        if (c == 4'd0) begin
            r = 4'd0;
        end else begin
            r = c - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface: decoded ID instruction in, stall controls out.
interface hazard_scoreboard_if #(
    parameter int ADDR_W = 5
);
    logic              id_valid;
    logic [ADDR_W-1:0] id_rs;
    logic [ADDR_W-1:0] id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic              id_early;
    logic              id_wr_en;
    logic [ADDR_W-1:0] id_wr_addr;
    logic [1:0]        id_wr_kind;
    logic              flush;
    logic              stall;
    logic              bubble;
    logic [3:0]        stall_cnt;
    logic              wd_err;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_early,
               id_wr_en, id_wr_addr, id_wr_kind, flush,
        input  stall, bubble, stall_cnt, wd_err
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_early,
               id_wr_en, id_wr_addr, id_wr_kind, flush,
        output stall, bubble, stall_cnt, wd_err
    );
endinterface

// File: rtl/hazard_sb_entry.sv
// One scoreboard slot: either captures a freshly issued write or takes
// the older neighbour's contents with its forwarding countdown stepped.
module hazard_sb_entry
    import pipe_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_load,
    input  sb_entry_t i_new,
    input  sb_entry_t i_prev,
    output sb_entry_t o_q
);

    sb_entry_t r_q;
    sb_entry_t w_nxt;

    // Select the next slot contents: new issue or shifted predecessor
    always_comb begin
        w_nxt = SB_EMPTY;
        if (i_load) begin
            w_nxt = i_new;
        end else begin
            w_nxt     = i_prev;
            w_nxt.cnt = cnt_dec(i_prev.cnt);
        end
    end

    // Slot register, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= SB_EMPTY;
        end else begin
            r_q <= w_nxt;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: tracks in-flight register writes in a shift
// register and stalls ID only when a source cannot yet be forwarded.
module hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 3,
    parameter int ALU_LAT   = 1,
    parameter int LOAD_LAT  = 2,
    parameter int LINK_LAT  = 1,
    parameter int ID_FWD    = 1,
    parameter int RF_BYPASS = 1,
    parameter int MAX_STALL = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    hazard_scoreboard_if.slave bus
);

    sb_entry_t             w_q [DEPTH];
    sb_entry_t             w_new;
    logic [SB_CNT_W-1:0]   w_lat;
    logic                  w_issue;
    logic [1:0]            w_haz;
    logic                  w_stall;
    logic [3:0]            w_cnt_nxt;
    logic                  w_wd_hit;
    logic [3:0]            r_stall_cnt;
    logic                  r_wd_err;

    // Forwarding latency of the ID instruction's result, by write kind
    always_comb begin
        w_lat = SB_CNT_W'(LOAD_LAT);
        case (bus.id_wr_kind)
            WR_ALU:  w_lat = SB_CNT_W'(ALU_LAT);
            WR_LOAD: w_lat = SB_CNT_W'(LOAD_LAT);
            WR_LINK: w_lat = SB_CNT_W'(LINK_LAT);
            default: w_lat = SB_CNT_W'(LOAD_LAT);
        endcase
    end

    // r0 is hardwired, so writes to it are never tracked
    assign w_issue = bus.id_valid & ~w_stall & ~bus.flush & bus.id_wr_en &
                     (bus.id_wr_addr != ADDR_W'(REG_ZERO));

    // Entry 0 candidate: the issuing write, or a bubble
    always_comb begin
        w_new = SB_EMPTY;
        if (w_issue) begin
            w_new.v    = 1'b1;
            w_new.addr = SB_ADDR_W'(bus.id_wr_addr);
            w_new.cnt  = w_lat;
        end else begin
            w_new = SB_EMPTY;
        end
    end

    // Shift chain: entry 0 loads from ID, the rest from their younger neighbour
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        if (g == 0) begin : g_head
            hazard_sb_entry u_entry (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_load (1'b1),
                .i_new  (w_new),
                .i_prev (SB_EMPTY),
                .o_q    (w_q[g])
            );
        end else begin : g_tail
            hazard_sb_entry u_entry (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_load (1'b0),
                .i_new  (SB_EMPTY),
                .i_prev (w_q[g-1]),
                .o_q    (w_q[g])
            );
        end
    end

    // Per-source hazard against the youngest matching in-flight write
    always_comb begin : p_hazard
        logic [ADDR_W-1:0]   w_src;
        logic                w_use;
        logic                w_m;
        logic                w_hit;
        logic                w_last;
        logic                w_need;
        logic [SB_CNT_W-1:0] w_cnt;
        w_haz  = 2'b00;
        w_src  = '0;
        w_use  = 1'b0;
        w_m    = 1'b0;
        w_hit  = 1'b0;
        w_last = 1'b0;
        w_need = 1'b0;
        w_cnt  = '0;
        for (int k = 0; k < 2; k++) begin
            w_src  = (k == 0) ? bus.id_rs : bus.id_rt;
            w_use  = (k == 0) ? bus.id_use_rs : bus.id_use_rt;
            w_hit  = 1'b0;
            w_last = 1'b0;
            w_cnt  = '0;
            // Walk oldest to youngest so the youngest match overrides
            for (int i = DEPTH - 1; i >= 0; i--) begin
                w_m    = w_q[i].v && (w_q[i].addr == SB_ADDR_W'(w_src));
                w_hit  = w_hit | w_m;
                w_cnt  = w_m ? w_q[i].cnt : w_cnt;
                w_last = w_m ? (i == DEPTH - 1) : w_last;
            end
            if (bus.id_early) begin
                if (ID_FWD != 0) begin
                    w_need = (w_cnt >= 4'd1);
                end else begin
                    w_need = 1'b1;
                end
            end else begin
                w_need = (w_cnt >= 4'd2);
            end
            w_haz[k] = w_use && (w_src != ADDR_W'(REG_ZERO)) && w_hit &&
                       (w_need || ((RF_BYPASS == 0) && w_last));
        end
    end

    // Flush kills the instruction, so it overrides any hazard
    assign w_stall = bus.id_valid & ~bus.flush & (|w_haz);

    // Next consecutive-stall count, saturating at 15
    always_comb begin
        w_cnt_nxt = 4'd0;
        if (w_stall) begin
            if (r_stall_cnt == 4'd15) begin
                w_cnt_nxt = 4'd15;
            end else begin
                w_cnt_nxt = r_stall_cnt + 4'd1;
            end
        end else begin
            w_cnt_nxt = 4'd0;
        end
    end

    assign w_wd_hit = (w_cnt_nxt != 4'd0) && (32'(w_cnt_nxt) == 32'(MAX_STALL));

    // Stall counter and sticky watchdog flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 4'd0;
            r_wd_err    <= 1'b0;
        end else begin
            r_stall_cnt <= w_cnt_nxt;
            r_wd_err    <= r_wd_err | w_wd_hit;
        end
    end

    assign bus.stall     = w_stall;
    assign bus.bubble    = w_stall | bus.flush;
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.wd_err    = r_wd_err;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two configurations driven with the same
// directed and random instruction stream, checked against a model that
// derives each write's pipeline position and readiness from its issue cycle.
module tb_hazard_scoreboard;
    import pipe_pkg::*;

    localparam int DEPTH    = 3;
    localparam int ALU_LAT  = 1;
    localparam int LOAD_LAT = 2;
    localparam int LINK_LAT = 1;

    logic clk;
    logic rst_n;

    hazard_scoreboard_if #(.ADDR_W(5)) bus_a ();
    hazard_scoreboard_if #(.ADDR_W(5)) bus_b ();

    hazard_scoreboard #(
        .ADDR_W(5), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT),
        .LINK_LAT(LINK_LAT), .ID_FWD(1), .RF_BYPASS(1), .MAX_STALL(15)
    ) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

    hazard_scoreboard #(
        .ADDR_W(5), .DEPTH(DEPTH), .ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT),
        .LINK_LAT(LINK_LAT), .ID_FWD(0), .RF_BYPASS(0), .MAX_STALL(3)
    ) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    logic [1:0] d_stall;
    logic [1:0] d_bubble;
    logic [1:0] d_wd;
    logic [3:0] d_sc [2];

    assign d_stall  = {bus_b.stall, bus_a.stall};
    assign d_bubble = {bus_b.bubble, bus_a.bubble};
    assign d_wd     = {bus_b.wd_err, bus_a.wd_err};
    assign d_sc[0]  = bus_a.stall_cnt;
    assign d_sc[1]  = bus_b.stall_cnt;

    // Reference model state
    typedef struct {
        int k;
        int addr;
        int lat;
        int t;
    } wr_t;

    wr_t   q[$];
    int    cyc;
    int    m_sc [2];
    bit    m_wd [2];
    bit    cfg_fwd [2] = '{1'b1, 1'b0};
    bit    cfg_byp [2] = '{1'b1, 1'b0};
    int    cfg_max [2] = '{15, 3};
    string nm [2]      = '{"a", "b"};

    int obs_stall [2];
    int obs_sc [2];
    int obs_wd [2];

    int n_vec;
    int n_err;

    // Free-running clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_lat(input int kind);
        case (kind)
            0:       return ALU_LAT;
            1:       return LOAD_LAT;
            2:       return LINK_LAT;
            default: return LOAD_LAT;
        endcase
    endfunction

    // A write issued in cycle t sits p = now-t-1 stages past ID and is
    // ready once lat-p reaches zero; only the youngest same-register write counts.
    function automatic bit m_haz(input int k, input int s, input bit use_s, input bit early);
        int best_t;
        int best_p;
        int best_cnt;
        int p;
        bit h;
        best_t   = -1;
        best_p   = 0;
        best_cnt = 0;
        if (!use_s || s == 0) return 1'b0;
        foreach (q[i]) begin
            p = cyc - q[i].t - 1;
            if (q[i].k == k && q[i].addr == s && p >= 0 && p < DEPTH && q[i].t > best_t) begin
                best_t   = q[i].t;
                best_p   = p;
                best_cnt = (q[i].lat - p > 0) ? q[i].lat - p : 0;
            end
        end
        if (best_t < 0) return 1'b0;
        if (early) h = cfg_fwd[k] ? (best_cnt >= 1) : 1'b1;
        else       h = (best_cnt >= 2);
        if (!cfg_byp[k] && best_p == DEPTH - 1) h = 1'b1;
        return h;
    endfunction

    task automatic drive(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                         input bit early, input bit wen, input int wa, input int kind, input bit fl);
        bus_a.id_valid = v;          bus_b.id_valid = v;
        bus_a.id_rs = 5'(rs);        bus_b.id_rs = 5'(rs);
        bus_a.id_rt = 5'(rt);        bus_b.id_rt = 5'(rt);
        bus_a.id_use_rs = urs;       bus_b.id_use_rs = urs;
        bus_a.id_use_rt = urt;       bus_b.id_use_rt = urt;
        bus_a.id_early = early;      bus_b.id_early = early;
        bus_a.id_wr_en = wen;        bus_b.id_wr_en = wen;
        bus_a.id_wr_addr = 5'(wa);   bus_b.id_wr_addr = 5'(wa);
        bus_a.id_wr_kind = 2'(kind); bus_b.id_wr_kind = 2'(kind);
        bus_a.flush = fl;            bus_b.flush = fl;
    endtask

    task automatic model_reset();
        q.delete();
        for (int k = 0; k < 2; k++) begin
            m_sc[k] = 0;
            m_wd[k] = 1'b0;
        end
    endtask

    // One ID cycle: drive, compare both configurations, advance the model
    task automatic step(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                        input bit early, input bit wen, input int wa, input int kind, input bit fl);
        bit ms [2];
        @(negedge clk);
        drive(v, rs, rt, urs, urt, early, wen, wa, kind, fl);
        #1;
        for (int k = 0; k < 2; k++) begin
            ms[k] = v && !fl && (m_haz(k, rs, urs, early) || m_haz(k, rt, urt, early));
            check({nm[k], "_stall"},  int'(d_stall[k]),  int'(ms[k]));
            check({nm[k], "_bubble"}, int'(d_bubble[k]), int'(ms[k] || fl));
            check({nm[k], "_scnt"},   int'(d_sc[k]),     m_sc[k]);
            check({nm[k], "_wd"},     int'(d_wd[k]),     int'(m_wd[k]));
            obs_stall[k] = int'(d_stall[k]);
            obs_sc[k]    = int'(d_sc[k]);
            obs_wd[k]    = int'(d_wd[k]);
        end
        for (int k = 0; k < 2; k++) begin
            if (v && !ms[k] && !fl && wen && wa != 0) q.push_back('{k, wa, m_lat(kind), cyc});
            m_sc[k] = ms[k] ? ((m_sc[k] < 15) ? m_sc[k] + 1 : 15) : 0;
            if (m_sc[k] == cfg_max[k]) m_wd[k] = 1'b1;
        end
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (cyc - q[i].t >= DEPTH) q.delete(i);
        end
        @(posedge clk);
        cyc++;
    endtask

    initial begin
        clk   = 1'b0;
        rst_n = 1'b0;
        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        model_reset();
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check({nm[k], "_rst_stall"},  int'(d_stall[k]),  0);
            check({nm[k], "_rst_bubble"}, int'(d_bubble[k]), 0);
            check({nm[k], "_rst_scnt"},   int'(d_sc[k]),     0);
            check({nm[k], "_rst_wd"},     int'(d_wd[k]),     0);
        end
        rst_n = 1'b1;

        // Load r8, then ALU op reading r8: exactly one stall
        step(1, 0, 0, 0, 0, 0, 1, 8, 1, 0);
        step(1, 8, 0, 1, 0, 0, 1, 10, 0, 0);
        check("lu_stall1", obs_stall[0], 1);
        check("lu_scnt1", obs_sc[0], 0);
        step(1, 8, 0, 1, 0, 0, 1, 10, 0, 0);
        check("lu_stall2", obs_stall[0], 0);
        check("lu_scnt2", obs_sc[0], 1);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("lu_scnt3", obs_sc[0], 0);

        // ALU r9 then beq r9: one stall
        step(1, 0, 0, 0, 0, 0, 1, 9, 0, 0);
        step(1, 9, 0, 1, 0, 1, 0, 0, 0, 0);
        check("alu_br1", obs_stall[0], 1);
        step(1, 9, 0, 1, 0, 1, 0, 0, 0, 0);
        check("alu_br2", obs_stall[0], 0);

        // Load r9 then beq r9 (on rt): two stalls
        step(1, 0, 0, 0, 0, 0, 1, 9, 1, 0);
        step(1, 0, 9, 0, 1, 1, 0, 0, 0, 0);
        check("ld_br1", obs_stall[0], 1);
        step(1, 0, 9, 0, 1, 1, 0, 0, 0, 0);
        check("ld_br2", obs_stall[0], 1);
        step(1, 0, 9, 0, 1, 1, 0, 0, 0, 0);
        check("ld_br3", obs_stall[0], 0);

        // JAL then JR r31: no ID forwarding holds until retirement
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 1, REG_RA, 2, 0);
        step(1, REG_RA, 0, 1, 0, 1, 0, 0, 0, 0);
        check("jr_a1", obs_stall[0], 1);
        check("jr_b1", obs_stall[1], 1);
        step(1, REG_RA, 0, 1, 0, 1, 0, 0, 0, 0);
        check("jr_a2", obs_stall[0], 0);
        check("jr_b2", obs_stall[1], 1);
        step(1, REG_RA, 0, 1, 0, 1, 0, 0, 0, 0);
        check("jr_b3", obs_stall[1], 1);
        step(1, REG_RA, 0, 1, 0, 1, 0, 0, 0, 0);
        check("jr_b4", obs_stall[1], 0);
        check("jr_b_wd", obs_wd[1], 1);

        // r0 is never tracked; younger ready write hides an older load
        step(1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        step(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        check("r0_nostall", obs_stall[0], 0);
        step(1, 0, 0, 0, 0, 0, 1, 5, 1, 0);
        step(1, 0, 0, 0, 0, 0, 1, 5, 0, 0);
        step(1, 5, 5, 1, 1, 0, 0, 0, 0, 0);
        check("young_ready", obs_stall[0], 0);

        // Flush beats a hazard and issues nothing
        step(1, 0, 0, 0, 0, 0, 1, 12, 1, 0);
        step(1, 12, 0, 1, 0, 0, 1, 13, 0, 1);
        check("fl_stall", obs_stall[0], 0);
        step(1, 13, 0, 1, 0, 1, 0, 0, 0, 0);
        check("fl_noissue", obs_stall[0], 0);

        // Random instruction stream over a small register set
        for (int n = 0; n < 400; n++) begin
            step(($urandom % 8) != 0, $urandom % 8, $urandom % 8, $urandom % 2, $urandom % 2,
                 ($urandom % 4) == 0, $urandom % 2, $urandom % 8, $urandom % 4,
                 ($urandom % 10) == 0);
        end

        // Asynchronous reset in the middle of a load-use stall
        step(1, 0, 0, 0, 0, 0, 1, 6, 1, 0);
        @(negedge clk);
        drive(1, 6, 0, 1, 0, 0, 0, 0, 0, 0);
        #1;
        check("pre_rst_stall", int'(d_stall[0]), 1);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check({nm[k], "_mid_rst_stall"},  int'(d_stall[k]),  0);
            check({nm[k], "_mid_rst_bubble"}, int'(d_bubble[k]), 0);
            check({nm[k], "_mid_rst_scnt"},   int'(d_sc[k]),     0);
            check({nm[k], "_mid_rst_wd"},     int'(d_wd[k]),     0);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 6, 0, 1, 0, 1, 0, 0, 0, 0);
        check("post_rst_stall", obs_stall[1], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
